// File: rtl/mailbox_pkg.sv
// Shared definitions for the APB3 stream mailbox: register map, bit positions
// and the APB transfer FSM encoding.
package mailbox_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_ERR    = 3'd4;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;

  localparam int CTRL_IRQ_RX_EN  = 0;
  localparam int CTRL_IRQ_TXE_EN = 1;
  localparam int CTRL_IRQ_ERR_EN = 2;
  localparam int CTRL_TX_FLUSH   = 3;
  localparam int CTRL_RX_FLUSH   = 4;

  localparam int ERR_TX_TIMEOUT = 0;
  localparam int ERR_RX_TIMEOUT = 1;
  localparam int ERR_ADDR       = 2;

  typedef enum logic {
    XFER_IDLE   = 1'b0,
    XFER_ACCESS = 1'b1
  } xfer_state_e;

endpackage

// File: rtl/mbx_sync_fifo.sv
// Single-clock FIFO with registered occupancy count, synchronous flush and
// a combinational head-of-queue output.
module mbx_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // flush wins over any same-cycle stream beat, which is dropped
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb3_stream_mailbox.sv
// APB3 slave bridging CPU register accesses to a TX and an RX valid/ready
// stream, with PREADY stalls on blocked FIFOs and a bounded timeout error.
//
// state       | meaning
// XFER_IDLE   | no transfer in access phase; wait counter held at zero
// XFER_ACCESS | setup seen; completes on PREADY, aborts if PSEL drops
module apb3_stream_mailbox
  import mailbox_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] TX_TDATA,
  output logic        TX_TVALID,
  input  logic        TX_TREADY,
  input  logic [31:0] RX_TDATA,
  input  logic        RX_TVALID,
  output logic        RX_TREADY,
  output logic        IRQ
);

  localparam int         TXCW        = $clog2(TX_DEPTH) + 1;
  localparam int         RXCW        = $clog2(RX_DEPTH) + 1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  xfer_state_e state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [2:0]  ctrl_q;
  logic [2:0]  err_q;
  logic        irq_q;
  logic        rdy_en_q;

  logic [2:0]  idx;
  logic        access, addr_bad, blocked, timed_out, complete, wr_cmp, rd_cmp, ctrl_wr;
  logic        tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [TXCW-1:0] tx_count;
  logic [RXCW-1:0] rx_count;
  logic [31:0] rx_head, status, rdata;
  logic [2:0]  err_set, err_clr;
  logic        unused_paddr;

  assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};
  assign idx          = PADDR[4:2];

  // gating on the FSM keeps PREADY low while reset holds the FSM in IDLE
  assign access    = PSEL & PENABLE & (state == XFER_ACCESS);
  assign blocked   = ((idx == REG_TXDATA) &  PWRITE & tx_full) |
                     ((idx == REG_RXDATA) & ~PWRITE & rx_empty);
  assign timed_out = access & blocked & (wait_cnt == TIMEOUT_CNT);

  always_comb begin
    addr_bad = 1'b1;
    case (idx)
      REG_TXDATA: addr_bad = ~PWRITE;
      REG_RXDATA: addr_bad = PWRITE;
      REG_STATUS: addr_bad = PWRITE;
      REG_CTRL:   addr_bad = 1'b0;
      REG_ERR:    addr_bad = 1'b0;
      default:    addr_bad = 1'b1;
    endcase
  end

  assign PREADY   = access & (~blocked | timed_out);
  assign PSLVERR  = access & (addr_bad | timed_out);
  assign complete = PREADY & ~PSLVERR;
  assign wr_cmp   = complete & PWRITE;
  assign rd_cmp   = complete & ~PWRITE;
  assign ctrl_wr  = wr_cmp & (idx == REG_CTRL);

  assign tx_push  = wr_cmp & (idx == REG_TXDATA);
  assign rx_pop   = rd_cmp & (idx == REG_RXDATA);
  assign tx_flush = ctrl_wr & PWDATA[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & PWDATA[CTRL_RX_FLUSH];

  assign TX_TVALID = ~tx_empty;
  assign tx_pop    = TX_TVALID & TX_TREADY;
  assign RX_TREADY = rdy_en_q & ~rx_full;
  assign rx_push   = RX_TVALID & RX_TREADY;

  assign err_set[ERR_TX_TIMEOUT] = timed_out & PWRITE;
  assign err_set[ERR_RX_TIMEOUT] = timed_out & ~PWRITE;
  assign err_set[ERR_ADDR]       = access & addr_bad;
  assign err_clr = (wr_cmp && idx == REG_ERR) ? PWDATA[2:0] : 3'b000;

  always_comb begin
    status = '0;
    status[ST_TX_FULL]            = tx_full;
    status[ST_TX_EMPTY]           = tx_empty;
    status[ST_RX_FULL]            = rx_full;
    status[ST_RX_EMPTY]           = rx_empty;
    status[ST_TX_CNT_LSB +: 8]    = 8'(tx_count);
    status[ST_RX_CNT_LSB +: 8]    = 8'(rx_count);
    case (idx)
      REG_RXDATA: rdata = rx_head;
      REG_STATUS: rdata = status;
      REG_CTRL:   rdata = {29'd0, ctrl_q};
      REG_ERR:    rdata = {29'd0, err_q};
      default:    rdata = '0;
    endcase
  end

  assign PRDATA = rd_cmp ? rdata : 32'd0;
  assign IRQ    = irq_q;

  always_comb begin
    state_nxt = state;
    case (state)
      XFER_IDLE:   if (PSEL && !PENABLE) state_nxt = XFER_ACCESS;
      XFER_ACCESS: if (!PSEL || PREADY)  state_nxt = XFER_IDLE;
      default:     state_nxt = XFER_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state    <= XFER_IDLE;
      wait_cnt <= '0;
      ctrl_q   <= '0;
      err_q    <= '0;
      irq_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      rdy_en_q <= 1'b1;
      if (state == XFER_IDLE)                wait_cnt <= '0;
      else if (access && blocked && !PREADY) wait_cnt <= wait_cnt + 8'd1;
      if (ctrl_wr) ctrl_q <= PWDATA[2:0];
      err_q <= (err_q & ~err_clr) | err_set;
      irq_q <= (ctrl_q[CTRL_IRQ_RX_EN]  & ~rx_empty) |
               (ctrl_q[CTRL_IRQ_TXE_EN] &  tx_empty) |
               (ctrl_q[CTRL_IRQ_ERR_EN] & (|err_q));
    end
  end

  mbx_sync_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETN),
    .push      (tx_push),
    .push_data (PWDATA),
    .pop       (tx_pop),
    .flush     (tx_flush),
    .head      (TX_TDATA),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  mbx_sync_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETN),
    .push      (rx_push),
    .push_data (RX_TDATA),
    .pop       (rx_pop),
    .flush     (rx_flush),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

endmodule

// File: tb/tb_apb3_stream_mailbox.sv
// Directed bench for apb3_stream_mailbox: dut_a uses TIMEOUT=255, dut_b uses
// TIMEOUT=0 with an idle RX stream; both share the APB bus except PSEL.
module tb_apb3_stream_mailbox;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic        psel_a = 1'b0;
  logic        psel_b = 1'b0;

  logic [31:0] prdata_a, prdata_b, tx_tdata_a, tx_tdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic        tx_tvalid_a, tx_tvalid_b, rx_tready_a, rx_tready_b, irq_a, irq_b;
  logic        tx_tready_a = 1'b0;
  logic [31:0] rx_tdata_a = '0;
  logic        rx_tvalid_a = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  apb3_stream_mailbox #(.TX_DEPTH(16), .RX_DEPTH(16), .TIMEOUT(255)) dut_a (
    .HCLK(HCLK), .HRESETN(HRESETN), .PADDR(PADDR), .PSEL(psel_a), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a), .TX_TDATA(tx_tdata_a), .TX_TVALID(tx_tvalid_a),
    .TX_TREADY(tx_tready_a), .RX_TDATA(rx_tdata_a), .RX_TVALID(rx_tvalid_a),
    .RX_TREADY(rx_tready_a), .IRQ(irq_a)
  );

  apb3_stream_mailbox #(.TX_DEPTH(16), .RX_DEPTH(16), .TIMEOUT(0)) dut_b (
    .HCLK(HCLK), .HRESETN(HRESETN), .PADDR(PADDR), .PSEL(psel_b), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b), .TX_TDATA(tx_tdata_b), .TX_TVALID(tx_tvalid_b),
    .TX_TREADY(1'b1), .RX_TDATA(32'd0), .RX_TVALID(1'b0),
    .RX_TREADY(rx_tready_b), .IRQ(irq_b)
  );

  // One APB transfer; returns at 1ns after the completing edge.
  // pulse_cycle > 0 raises TX_TREADY of dut_a during that access cycle only.
  task automatic apb_xfer(input bit use_b, input logic [31:0] addr, input bit wr,
                          input logic [31:0] wdata, input int pulse_cycle,
                          output logic [31:0] rdata, output logic err, output int cycles);
    int k;
    @(posedge HCLK); #1;
    if (use_b) psel_b = 1'b1; else psel_a = 1'b1;
    PADDR = addr; PWRITE = wr; PWDATA = wdata; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    k = 1;
    rdata = '0; err = 1'b0;
    forever begin
      if (pulse_cycle != 0) tx_tready_a = (k == pulse_cycle);
      @(negedge HCLK);
      if ((use_b ? pready_b : pready_a) === 1'b1) begin
        rdata = use_b ? prdata_b : prdata_a;
        err   = use_b ? pslverr_b : pslverr_a;
        break;
      end
      if (k >= 300) begin
        checks++; failures++;
        $display("FAIL apb_wait addr=%h: no PREADY after %0d cycles, required within 300", addr, k);
        err = 1'bx;
        break;
      end
      @(posedge HCLK); #1;
      k++;
    end
    cycles = k;
    @(posedge HCLK); #1;
    psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
    if (pulse_cycle != 0) tx_tready_a = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int cy;
    HRESETN = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    checks++; if ({prdata_a, pready_a, pslverr_a, tx_tvalid_a, rx_tready_a, irq_a} !== 37'd0) begin
      failures++; $display("FAIL reset_outputs got %h required 0",
        {prdata_a, pready_a, pslverr_a, tx_tvalid_a, rx_tready_a, irq_a}); end
    @(negedge HCLK); HRESETN = 1'b1; #1;
    checks++; if (rx_tready_a !== 1'b0) begin
      failures++; $display("FAIL rx_tready_before_edge got %b required 0", rx_tready_a); end
    @(posedge HCLK); #1;
    checks++; if (rx_tready_a !== 1'b1) begin
      failures++; $display("FAIL rx_tready_after_edge got %b required 1", rx_tready_a); end
    apb_xfer(0, 32'h08, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_000A) begin
      failures++; $display("FAIL reset_status got %h required 0000000a", rd); end
  endtask

  task automatic test_tx_basic();
    logic [31:0] rd; logic er; int cy;
    apb_xfer(0, 32'h00, 1, 32'hA5A5_0001, 0, rd, er, cy);
    checks++; if (cy !== 1 || er !== 1'b0) begin
      failures++; $display("FAIL tx_first_write cycles=%0d err=%b required 1/0", cy, er); end
    checks++; if (tx_tvalid_a !== 1'b1 || tx_tdata_a !== 32'hA5A5_0001) begin
      failures++; $display("FAIL tx_stream got valid=%b data=%h required 1/a5a50001", tx_tvalid_a, tx_tdata_a); end
    apb_xfer(0, 32'h08, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_0108) begin
      failures++; $display("FAIL tx_status_one got %h required 00000108", rd); end
  endtask

  task automatic test_tx_timeout();
    logic [31:0] rd; logic er; int cy;
    for (int i = 1; i < 16; i++) apb_xfer(0, 32'h00, 1, 32'h100 + i, 0, rd, er, cy);
    apb_xfer(0, 32'h08, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_1009) begin
      failures++; $display("FAIL tx_status_full got %h required 00001009", rd); end
    apb_xfer(0, 32'h00, 1, 32'hDEAD_0017, 0, rd, er, cy);
    checks++; if (cy !== 256 || er !== 1'b1) begin
      failures++; $display("FAIL tx_timeout cycles=%0d err=%b required 256/1", cy, er); end
    apb_xfer(0, 32'h10, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h1) begin
      failures++; $display("FAIL tx_timeout_err got %h required 00000001", rd); end
    apb_xfer(0, 32'h08, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_1009) begin
      failures++; $display("FAIL tx_count_after_timeout got %h required 00001009", rd); end
    apb_xfer(0, 32'h10, 1, 32'h1, 0, rd, er, cy);
    apb_xfer(0, 32'h10, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0) begin
      failures++; $display("FAIL err_w1c got %h required 00000000", rd); end
  endtask

  task automatic test_tx_unstall();
    logic [31:0] rd; logic er; int cy;
    apb_xfer(0, 32'h00, 1, 32'hBEEF_0018, 10, rd, er, cy);
    checks++; if (cy !== 11 || er !== 1'b0) begin
      failures++; $display("FAIL tx_unstall cycles=%0d err=%b required 11/0", cy, er); end
    checks++; if (tx_tdata_a !== 32'h101) begin
      failures++; $display("FAIL tx_head_after_pop got %h required 00000101", tx_tdata_a); end
    apb_xfer(0, 32'h08, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_1009) begin
      failures++; $display("FAIL tx_count_after_unstall got %h required 00001009", rd); end
  endtask

  task automatic test_rx();
    logic [31:0] rd; logic er; int cy;
    @(posedge HCLK); #1;
    rx_tvalid_a = 1'b1; rx_tdata_a = 32'h11;
    @(posedge HCLK); #1;
    rx_tdata_a = 32'h22;
    @(posedge HCLK); #1;
    rx_tvalid_a = 1'b0;
    apb_xfer(0, 32'h04, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h11 || cy !== 1 || er !== 1'b0) begin
      failures++; $display("FAIL rx_read0 got %h cyc=%0d err=%b required 00000011/1/0", rd, cy, er); end
    apb_xfer(0, 32'h04, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h22 || cy !== 1 || er !== 1'b0) begin
      failures++; $display("FAIL rx_read1 got %h cyc=%0d err=%b required 00000022/1/0", rd, cy, er); end
    apb_xfer(1, 32'h04, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0 || cy !== 1 || er !== 1'b1) begin
      failures++; $display("FAIL rx_timeout0 got %h cyc=%0d err=%b required 00000000/1/1", rd, cy, er); end
    apb_xfer(1, 32'h10, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h2) begin
      failures++; $display("FAIL rx_timeout_err got %h required 00000002", rd); end
  endtask

  task automatic test_irq_flush();
    logic [31:0] rd; logic er; int cy;
    apb_xfer(0, 32'h0C, 1, 32'h8, 0, rd, er, cy);
    checks++; if (tx_tvalid_a !== 1'b0) begin
      failures++; $display("FAIL tx_flush_full got valid=%b required 0", tx_tvalid_a); end
    apb_xfer(0, 32'h0C, 1, 32'h2, 0, rd, er, cy);
    checks++; if (irq_a !== 1'b0) begin
      failures++; $display("FAIL irq_same_cycle got %b required 0", irq_a); end
    @(posedge HCLK); #1;
    checks++; if (irq_a !== 1'b1) begin
      failures++; $display("FAIL irq_txe_rise got %b required 1", irq_a); end
    apb_xfer(0, 32'h00, 1, 32'h77, 0, rd, er, cy);
    checks++; if (tx_tvalid_a !== 1'b1 || irq_a !== 1'b1) begin
      failures++; $display("FAIL irq_lag got valid=%b irq=%b required 1/1", tx_tvalid_a, irq_a); end
    @(posedge HCLK); #1;
    checks++; if (irq_a !== 1'b0) begin
      failures++; $display("FAIL irq_txe_fall got %b required 0", irq_a); end
    apb_xfer(0, 32'h00, 1, 32'h78, 0, rd, er, cy);
    apb_xfer(0, 32'h00, 1, 32'h79, 0, rd, er, cy);
    apb_xfer(0, 32'h08, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_0308) begin
      failures++; $display("FAIL status_three got %h required 00000308", rd); end
    apb_xfer(0, 32'h0C, 1, 32'hA, 0, rd, er, cy);
    checks++; if (tx_tvalid_a !== 1'b0) begin
      failures++; $display("FAIL tx_flush_three got valid=%b required 0", tx_tvalid_a); end
    apb_xfer(0, 32'h0C, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h2) begin
      failures++; $display("FAIL ctrl_selfclear got %h required 00000002", rd); end
    apb_xfer(0, 32'h08, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_000A) begin
      failures++; $display("FAIL status_after_flush got %h required 0000000a", rd); end
  endtask

  task automatic test_addr_err();
    logic [31:0] rd; logic er; int cy;
    apb_xfer(0, 32'h1C, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0 || cy !== 1 || er !== 1'b1) begin
      failures++; $display("FAIL unmapped_read got %h cyc=%0d err=%b required 00000000/1/1", rd, cy, er); end
    apb_xfer(0, 32'h10, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h4) begin
      failures++; $display("FAIL addr_err_flag got %h required 00000004", rd); end
    apb_xfer(0, 32'h08, 1, 32'hFFFF_FFFF, 0, rd, er, cy);
    checks++; if (er !== 1'b1) begin
      failures++; $display("FAIL status_write_err got %b required 1", er); end
    apb_xfer(0, 32'h00, 0, 0, 0, rd, er, cy);
    checks++; if (er !== 1'b1) begin
      failures++; $display("FAIL txdata_read_err got %b required 1", er); end
    apb_xfer(0, 32'h10, 1, 32'h4, 0, rd, er, cy);
    apb_xfer(0, 32'h0B, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_000A || er !== 1'b0) begin
      failures++; $display("FAIL low_addr_bits got %h err=%b required 0000000a/0", rd, er); end
    apb_xfer(0, 32'h10, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0) begin
      failures++; $display("FAIL addr_err_clear got %h required 00000000", rd); end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] rd; logic er; int cy;
    apb_xfer(0, 32'h0C, 1, 32'h4, 0, rd, er, cy);
    apb_xfer(0, 32'h14, 1, 32'h0, 0, rd, er, cy);
    apb_xfer(0, 32'h00, 1, 32'h55, 0, rd, er, cy);
    checks++; if (irq_a !== 1'b1) begin
      failures++; $display("FAIL irq_err got %b required 1", irq_a); end
    @(posedge HCLK); #1;
    psel_a = 1'b1; PADDR = 32'h04; PWRITE = 1'b0; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    repeat (5) @(negedge HCLK);
    checks++; if (pready_a !== 1'b0) begin
      failures++; $display("FAIL rx_stall got pready=%b required 0", pready_a); end
    #2 HRESETN = 1'b0;
    #1;
    checks++; if ({prdata_a, pready_a, pslverr_a, tx_tvalid_a, rx_tready_a, irq_a} !== 37'd0) begin
      failures++; $display("FAIL reset_mid_stall got %h required 0",
        {prdata_a, pready_a, pslverr_a, tx_tvalid_a, rx_tready_a, irq_a}); end
    @(posedge HCLK); #1;
    psel_a = 1'b0; PENABLE = 1'b0;
    HRESETN = 1'b1;
    @(posedge HCLK); #1;
    apb_xfer(0, 32'h10, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0) begin
      failures++; $display("FAIL err_after_reset got %h required 00000000", rd); end
    apb_xfer(0, 32'h08, 0, 0, 0, rd, er, cy);
    checks++; if (rd !== 32'h0000_000A) begin
      failures++; $display("FAIL status_after_reset got %h required 0000000a", rd); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_timeout();
    test_tx_unstall();
    test_rx();
    test_irq_flush();
    test_addr_err();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
